// File: rtl/sm83_sp_bus_sched.sv
// Stack-pointer bit-cell column scheduler: precharge, then write or sample, then grant.
// Define SM83_SP_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority idu > ld > rd.

module sm83_sp_bus_sched #(
   parameter int unsigned PCH_CYC = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        idu_req,
   input  logic [15:0] idu_data,
   input  logic        ld_req,
   input  logic        ld_hi,
   input  logic [7:0]  ld_data,
   input  logic        rd_req,
   input  logic [15:0] bus_in,
   output logic        pch_n,
   output logic        ena_lo,
   output logic        ena_hi,
   output logic [15:0] bus_pd,
   output logic [15:0] rd_data,
   output logic        idu_gnt,
   output logic        ld_gnt,
   output logic        rd_gnt,
   output logic        busy
);

   if (PCH_CYC == 0 || PCH_CYC > 15) begin : g_pch_cyc_check
      $error("PCH_CYC must be in 1..15");
   end

   typedef enum logic [1:0] {StIdle, StPch, StEval, StGnt} state_e;

   localparam logic [1:0] IdIdu = 2'd0;
   localparam logic [1:0] IdLd  = 2'd1;
   localparam logic [1:0] IdRd  = 2'd2;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  win_q, win_d;
   logic [15:0] idu_op_q, idu_op_d;
   logic [7:0]  ld_op_q, ld_op_d;
   logic        ld_hi_q, ld_hi_d;

   logic        pch_n_q, pch_n_d;
   logic        ena_lo_q, ena_lo_d;
   logic        ena_hi_q, ena_hi_d;
   logic [15:0] bus_pd_q, bus_pd_d;
   logic [15:0] rd_data_q, rd_data_d;
   logic [2:0]  gnt_q, gnt_d;
   logic        busy_q, busy_d;

   logic [2:0]  req, cand;
   logic [1:0]  pick;
   logic        arb_en;

   assign req = {rd_req, ld_req, idu_req};

   // The requester being granted this cycle is not eligible for the next slot.
   always_comb begin
      cand = req;
      if (state_q == StGnt) cand = req & ~(3'b001 << win_q);
   end

`ifdef SM83_SP_SCHED_RR_EN
   logic [1:0] ptr_q, ptr_d;

   always_comb begin
      case (ptr_q)
         IdLd:    pick = cand[1] ? IdLd : (cand[2] ? IdRd : IdIdu);
         IdRd:    pick = cand[2] ? IdRd : (cand[0] ? IdIdu : IdLd);
         default: pick = cand[0] ? IdIdu : (cand[1] ? IdLd : IdRd);
      endcase
   end

   always_comb begin
      ptr_d = ptr_q;
      if (arb_en) ptr_d = (pick == IdRd) ? IdIdu : pick + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) ptr_q <= IdIdu;
      else          ptr_q <= ptr_d;
   end
`else
   always_comb begin
      pick = cand[0] ? IdIdu : (cand[1] ? IdLd : IdRd);
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      win_d    = win_q;
      idu_op_d = idu_op_q;
      ld_op_d  = ld_op_q;
      ld_hi_d  = ld_hi_q;
      arb_en   = 1'b0;
      case (state_q)
         StIdle: arb_en = |cand;
         StPch: begin
            if (cnt_q == 4'd0) state_d = StEval;
            else               cnt_d   = cnt_q - 4'd1;
         end
         StEval: state_d = StGnt;
         StGnt: begin
            if (|cand) arb_en  = 1'b1;
            else       state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (arb_en) begin
         state_d = StPch;
         cnt_d   = 4'(PCH_CYC - 1);
         win_d   = pick;
         if (pick == IdIdu) idu_op_d = idu_data;
         if (pick == IdLd) begin
            ld_op_d = ld_data;
            ld_hi_d = ld_hi;
         end
      end
   end

   // Outputs are decoded from the next state so every output leaves a flop.
   always_comb begin
      pch_n_d  = (state_d != StPch);
      ena_lo_d = 1'b0;
      ena_hi_d = 1'b0;
      bus_pd_d = 16'h0000;
      gnt_d    = 3'b000;
      busy_d   = (state_d != StIdle);
      if (state_d == StEval) begin
         case (win_d)
            IdIdu: begin
               ena_lo_d = 1'b1;
               ena_hi_d = 1'b1;
               bus_pd_d = ~idu_op_d;
            end
            IdLd: begin
               if (ld_hi_d) begin
                  ena_hi_d = 1'b1;
                  bus_pd_d = {~ld_op_d, 8'h00};
               end else begin
                  ena_lo_d = 1'b1;
                  bus_pd_d = {8'h00, ~ld_op_d};
               end
            end
            default: ;
         endcase
      end
      if (state_d == StGnt) gnt_d = 3'b001 << win_d;
      rd_data_d = rd_data_q;
      if (state_q == StEval && win_q == IdRd) rd_data_d = bus_in;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         win_q     <= IdIdu;
         idu_op_q  <= 16'h0000;
         ld_op_q   <= 8'h00;
         ld_hi_q   <= 1'b0;
         pch_n_q   <= 1'b1;
         ena_lo_q  <= 1'b0;
         ena_hi_q  <= 1'b0;
         bus_pd_q  <= 16'h0000;
         rd_data_q <= 16'h0000;
         gnt_q     <= 3'b000;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         win_q     <= win_d;
         idu_op_q  <= idu_op_d;
         ld_op_q   <= ld_op_d;
         ld_hi_q   <= ld_hi_d;
         pch_n_q   <= pch_n_d;
         ena_lo_q  <= ena_lo_d;
         ena_hi_q  <= ena_hi_d;
         bus_pd_q  <= bus_pd_d;
         rd_data_q <= rd_data_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
      end
   end

   assign pch_n   = pch_n_q;
   assign ena_lo  = ena_lo_q;
   assign ena_hi  = ena_hi_q;
   assign bus_pd  = bus_pd_q;
   assign rd_data = rd_data_q;
   assign idu_gnt = gnt_q[0];
   assign ld_gnt  = gnt_q[1];
   assign rd_gnt  = gnt_q[2];
   assign busy    = busy_q;

endmodule

// File: tb/tb_sm83_sp_bus_sched.sv
// Bench for sm83_sp_bus_sched: transaction-level reference model, directed cases, random traffic.
// Honours SM83_SP_SCHED_RR_EN to pick the expected arbitration policy.

module tb_sm83_sp_bus_sched;

   localparam int P = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        idu_req = 1'b0, ld_req = 1'b0, rd_req = 1'b0, ld_hi = 1'b0;
   logic [15:0] idu_data = 16'h0, bus_in = 16'h0;
   logic [7:0]  ld_data = 8'h0;
   logic        pch_n, ena_lo, ena_hi, idu_gnt, ld_gnt, rd_gnt, busy;
   logic [15:0] bus_pd, rd_data;

   always #5 clk = ~clk;

   sm83_sp_bus_sched #(.PCH_CYC(P)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .idu_req  (idu_req),
      .idu_data (idu_data),
      .ld_req   (ld_req),
      .ld_hi    (ld_hi),
      .ld_data  (ld_data),
      .rd_req   (rd_req),
      .bus_in   (bus_in),
      .pch_n    (pch_n),
      .ena_lo   (ena_lo),
      .ena_hi   (ena_hi),
      .bus_pd   (bus_pd),
      .rd_data  (rd_data),
      .idu_gnt  (idu_gnt),
      .ld_gnt   (ld_gnt),
      .rd_gnt   (rd_gnt),
      .busy     (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: one transaction in flight, described by its winner and start edge.
   bit          m_act = 0;
   int          m_win = 0, m_start = 0, m_ptr = 0, n = 0;
   logic [15:0] m_idu = 0, m_rd = 0;
   logic [7:0]  m_ld = 0;
   logic        m_hi = 0;
   logic        e_pch_n = 1, e_ena_lo = 0, e_ena_hi = 0, e_busy = 0;
   logic [15:0] e_bus_pd = 0;
   logic [2:0]  e_gnt = 0;

   bit          log_en = 0;
   int          stepno = 0;
   logic [2:0]  rec_g[$];
   int          rec_t[$];

   function automatic int pick_model(input logic [2:0] r, input int ptr);
      for (int i = 0; i < 3; i++) if (r[(ptr + i) % 3]) return (ptr + i) % 3;
      return 0;
   endfunction

   task automatic model_edge();
      logic [2:0] r;
      int d;
      bit arb;
      e_pch_n = 1; e_ena_lo = 0; e_ena_hi = 0; e_bus_pd = 0; e_gnt = 0; e_busy = 0;
      if (!reset_n) begin
         m_act = 0; m_ptr = 0; m_rd = 0;
      end else begin
         r = {rd_req, ld_req, idu_req};
         arb = 0;
         if (m_act) begin
            d = n - m_start;
            if (d == P + 1 && m_win == 2) m_rd = bus_in;
            if (d == P + 2) begin
               m_act = 0;
               r[m_win] = 1'b0;
               arb = 1;
            end
         end else arb = 1;
         if (arb && r != 3'b000) begin
`ifdef SM83_SP_SCHED_RR_EN
            m_win = pick_model(r, m_ptr);
            m_ptr = (m_win + 1) % 3;
`else
            m_win = pick_model(r, 0);
`endif
            m_act = 1; m_start = n;
            m_idu = idu_data; m_ld = ld_data; m_hi = ld_hi;
         end
         if (m_act) begin
            d = n - m_start;
            e_busy = 1;
            if (d < P) e_pch_n = 0;
            else if (d == P) begin
               if (m_win == 0) begin
                  e_ena_lo = 1; e_ena_hi = 1; e_bus_pd = ~m_idu;
               end else if (m_win == 1) begin
                  if (m_hi) begin e_ena_hi = 1; e_bus_pd = {~m_ld, 8'h00}; end
                  else      begin e_ena_lo = 1; e_bus_pd = {8'h00, ~m_ld}; end
               end
            end else e_gnt[m_win] = 1'b1;
         end
      end
      n++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("pch_n", pch_n, e_pch_n);
      check_eq("ena_lo", ena_lo, e_ena_lo);
      check_eq("ena_hi", ena_hi, e_ena_hi);
      check_eq("bus_pd", bus_pd, e_bus_pd);
      check_eq("gnt", {rd_gnt, ld_gnt, idu_gnt}, e_gnt);
      check_eq("busy", busy, e_busy);
      check_eq("rd_data", rd_data, m_rd);
      if (log_en && (idu_gnt || ld_gnt || rd_gnt)) begin
         rec_g.push_back({rd_gnt, ld_gnt, idu_gnt});
         rec_t.push_back(stepno);
      end
      stepno++;
   endtask

   task automatic rand_stim();
      logic [2:0] r;
      r = {rd_req, ld_req, idu_req};
      for (int i = 0; i < 3; i++) begin
         if (e_gnt[i]) r[i] = 1'($urandom_range(0, 1));
         else if (r[i] && m_act && m_win == i) begin
            if ($urandom_range(0, 7) == 0) r[i] = 1'b0;
         end else if (!r[i] && !(m_act && m_win == i) && $urandom_range(0, 2) == 0) r[i] = 1'b1;
      end
      {rd_req, ld_req, idu_req} = r;
      idu_data = 16'($urandom);
      ld_data  = 8'($urandom);
      ld_hi    = 1'($urandom_range(0, 1));
      bus_in   = 16'($urandom);
      reset_n  = ($urandom_range(0, 149) != 0);
   endtask

   logic [2:0] exp_order [4];

   initial begin
`ifdef SM83_SP_SCHED_RR_EN
      exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
      exp_order = '{3'b001, 3'b010, 3'b001, 3'b010};
`endif
      // Reset held with every request asserted, then full contention.
      reset_n = 0; idu_req = 1; ld_req = 1; rd_req = 1; idu_data = 16'h1234;
      repeat (3) step();
      check_eq("reset_busy", busy, 1'b0);
      check_eq("reset_pch_n", pch_n, 1'b1);
      reset_n = 1; log_en = 1; stepno = 0;
      repeat (4 * (P + 2)) step();
      log_en = 0;
      check_eq("n_grants", rec_g.size(), 4);
      for (int i = 0; i < 4 && i < rec_g.size(); i++) begin
         check_eq("grant_order", rec_g[i], exp_order[i]);
         check_eq("grant_cycle", rec_t[i], P + 1 + i * (P + 2));
      end

      // IDU write of FFFE, then reset during its EVAL.
      idu_req = 0; ld_req = 0; rd_req = 0; reset_n = 0;
      step();
      reset_n = 1; idu_req = 1; idu_data = 16'hFFFE;
      repeat (P + 1) step();
      check_eq("idu_eval_pd", bus_pd, 16'h0001);
      check_eq("idu_eval_ena", {ena_hi, ena_lo}, 2'b11);
      reset_n = 0;
      step();
      check_eq("rst_eval_gnt", idu_gnt, 1'b0);
      check_eq("rst_eval_ena", {ena_hi, ena_lo}, 2'b00);
      idu_req = 0; reset_n = 1;
      step();

      // High-byte load whose inputs change during precharge.
      ld_req = 1; ld_hi = 1; ld_data = 8'hC0;
      step();
      ld_hi = 0; ld_data = 8'h55;
      repeat (P) step();
      check_eq("ld_eval_pd", bus_pd, 16'h3F00);
      check_eq("ld_eval_ena", {ena_hi, ena_lo}, 2'b10);
      step();
      check_eq("ld_gnt", ld_gnt, 1'b1);
      ld_req = 0;
      step();

      // Read: bus_in only meaningful during EVAL.
      rd_req = 1; bus_in = 16'h0000;
      repeat (P + 1) step();
      bus_in = 16'hDFFF;
      step();
      check_eq("rd_gnt_data", rd_data, 16'hDFFF);
      check_eq("rd_gnt", rd_gnt, 1'b1);
      rd_req = 0; bus_in = 16'h0000;
      repeat (3) step();
      check_eq("rd_hold", rd_data, 16'hDFFF);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rand_stim();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
